// File: rtl/expand_bits_pkg.sv
// Shared constants and helpers for the count-to-thermometer-mask expander.
package expand_bits_pkg;

    localparam int unsigned FILL_W  = 3;
    localparam int unsigned GROUP_W = 4;

    typedef logic [FILL_W-1:0] fill_t;

    // Ceiling log2, used to size the count input from the mask width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Fill code to 4-bit thermometer pattern; codes above 4 saturate.
    function automatic logic [GROUP_W-1:0] expand_4(input fill_t fill);
        logic [GROUP_W-1:0] pattern;
        case (fill)
            3'd0:    pattern = 4'b0000;
            3'd1:    pattern = 4'b0001;
            3'd2:    pattern = 4'b0011;
            3'd3:    pattern = 4'b0111;
            default: pattern = 4'b1111;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/expand_bits_group.sv
// Register-free fill computation for one 4-bit group: min(max(count - 4*group, 0), 4).
module expand_bits_group
    import expand_bits_pkg::*;
#(
    parameter int unsigned CntBits = 6,
    parameter int unsigned Group   = 0
) (
    input  logic [CntBits-1:0] count,
    output fill_t              fill_c
);

    localparam logic signed [CntBits:0] BASE = (CntBits+1)'(GROUP_W * Group);
    localparam logic signed [CntBits:0] FULL = (CntBits+1)'(GROUP_W);

    logic signed [CntBits:0] diff;

    // One extra sign bit keeps the subtraction from wrapping.
    assign diff = $signed({1'b0, count}) - BASE;

    always_comb begin
        fill_c = '0;
        if (diff[CntBits]) begin
            fill_c = '0;
        end else if (diff >= FULL) begin
            fill_c = FILL_W'(GROUP_W);
        end else begin
            fill_c = FILL_W'(diff);
        end
    end

endmodule

// File: rtl/expand_bits.sv
// Two-stage count -> thermometer mask pipeline with enable-based stall.
// Optional macro EXPAND_BITS_OVF_CHECK_EN adds an `ovf` output flagging count > OutBits.
module expand_bits
    import expand_bits_pkg::*;
#(
    parameter  int unsigned OutBits = 32,
    localparam int unsigned CntBits = clog2(OutBits + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    input  logic [CntBits-1:0] count,
`ifdef EXPAND_BITS_OVF_CHECK_EN
    output logic               ovf,
`endif
    output logic               out_valid,
    output logic [OutBits-1:0] mask
);

    localparam int unsigned GROUPS = OutBits / GROUP_W;

    logic [GROUPS-1:0][FILL_W-1:0] fill_c;
    logic [GROUPS-1:0][FILL_W-1:0] fill_q;
    logic [OutBits-1:0]            mask_c;
    logic                          valid_q;

    for (genvar g = 0; g < GROUPS; g++) begin : g_group
        expand_bits_group #(
            .CntBits (CntBits),
            .Group   (g)
        ) u_group (
            .count  (count),
            .fill_c (fill_c[g])
        );
    end

    // Stage-2 LUT expansion of the registered fill codes.
    always_comb begin
        mask_c = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            mask_c[g*GROUP_W +: GROUP_W] = expand_4(fill_q[g]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            fill_q    <= '0;
            out_valid <= 1'b0;
            mask      <= '0;
        end else if (en) begin
            valid_q   <= in_valid;
            fill_q    <= fill_c;
            out_valid <= valid_q;
            mask      <= mask_c;
        end
    end

`ifdef EXPAND_BITS_OVF_CHECK_EN
    logic ovf_q;

    // Overflow flag travels with the fill codes so it stays aligned with mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            ovf   <= 1'b0;
        end else if (en) begin
            ovf_q <= (count > CntBits'(OutBits));
            ovf   <= ovf_q;
        end
    end
`endif

endmodule

// File: tb/tb_expand_bits.sv
// Scoreboard bench for expand_bits: OutBits=32 and OutBits=4 instances driven in lockstep.
module tb_expand_bits;

    typedef struct {
        logic        valid;
        logic        ovf;
        logic [31:0] mask;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [5:0]  count32;
    logic [2:0]  count4;
    logic        out_valid32;
    logic        out_valid4;
    logic [31:0] mask32;
    logic [3:0]  mask4;
    logic        ovf32;
    logic        ovf4;

    logic [31:0] exp_mask32;
    logic [3:0]  exp_mask4;
    logic        exp_ovf32;
    logic        exp_ovf4;

    exp_t q32[$];
    exp_t q4[$];
    exp_t held32;
    exp_t held4;
    logic edge_en;

    int checks;
    int errors;

    expand_bits #(.OutBits(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .count     (count32),
`ifdef EXPAND_BITS_OVF_CHECK_EN
        .ovf       (ovf32),
`endif
        .out_valid (out_valid32),
        .mask      (mask32)
    );

    expand_bits #(.OutBits(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .count     (count4),
`ifdef EXPAND_BITS_OVF_CHECK_EN
        .ovf       (ovf4),
`endif
        .out_valid (out_valid4),
        .mask      (mask4)
    );

`ifndef EXPAND_BITS_OVF_CHECK_EN
    assign ovf32 = 1'b0;
    assign ovf4  = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Issue side: every enabled, out-of-reset edge pushes the expected response.
    always @(posedge clk) begin
        edge_en = rst_n && en;
        if (edge_en) begin
            q32.push_back('{valid: in_valid, ovf: exp_ovf32, mask: exp_mask32});
            q4.push_back('{valid: in_valid, ovf: exp_ovf4, mask: {28'd0, exp_mask4}});
        end
    end

    // Monitor: pops one entry per enabled edge, otherwise expects frozen outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid32", 32'(out_valid32), 32'd0);
            check("rst_mask32", mask32, 32'd0);
            check("rst_valid4", 32'(out_valid4), 32'd0);
            check("rst_mask4", 32'(mask4), 32'd0);
        end else begin
            if (edge_en) begin
                if (q32.size() == 0 || q4.size() == 0) begin
                    check("queue_underflow", 32'(q32.size()), 32'd1);
                end else begin
                    held32 = q32.pop_front();
                    held4  = q4.pop_front();
                end
            end
            check("valid32", 32'(out_valid32), 32'(held32.valid));
            check("mask32", mask32, held32.mask);
            check("valid4", 32'(out_valid4), 32'(held4.valid));
            check("mask4", 32'(mask4), held4.mask);
`ifdef EXPAND_BITS_OVF_CHECK_EN
            check("ovf32", 32'(ovf32), 32'(held32.ovf));
            check("ovf4", 32'(ovf4), 32'(held4.ovf));
`endif
        end
    end

    task automatic step(input logic e, input logic v, input int c32, input logic [31:0] m32,
                        input int c4, input logic [3:0] m4);
        en         = e;
        in_valid   = v;
        count32    = 6'(c32);
        exp_mask32 = m32;
        exp_ovf32  = (c32 > 32);
        count4     = 3'(c4);
        exp_mask4  = m4;
        exp_ovf4   = (c4 > 4);
        @(posedge clk);
        #2;
    endtask

    // Reset entry; after release the first enabled edge presents the cleared stage-1 data.
    task automatic enter_reset();
        rst_n = 1'b0;
        #1;
        check("async_valid32", 32'(out_valid32), 32'd0);
        check("async_valid4", 32'(out_valid4), 32'd0);
        q32.delete();
        q4.delete();
        q32.push_back('{valid: 1'b0, ovf: 1'b0, mask: 32'd0});
        q4.push_back('{valid: 1'b0, ovf: 1'b0, mask: 32'd0});
        held32 = '{valid: 1'b0, ovf: 1'b0, mask: 32'd0};
        held4  = '{valid: 1'b0, ovf: 1'b0, mask: 32'd0};
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        edge_en = 1'b0;
        rst_n   = 1'b0;
        en      = 1'b1;
        in_valid = 1'b1;
        count32 = 6'd17;
        count4  = 3'd3;
        exp_mask32 = 32'd0;
        exp_mask4  = 4'd0;
        exp_ovf32  = 1'b0;
        exp_ovf4   = 1'b0;
        enter_reset();

        // Hold reset with a valid input presented.
        repeat (3) step(1'b1, 1'b1, 17, 32'h0001_FFFF, 3, 4'h7);
        rst_n = 1'b1;

        // Back-to-back sweep.
        step(1'b1, 1'b1, 0,  32'h0000_0000, 0, 4'h0);
        step(1'b1, 1'b1, 1,  32'h0000_0001, 1, 4'h1);
        step(1'b1, 1'b1, 4,  32'h0000_000F, 2, 4'h3);
        step(1'b1, 1'b1, 5,  32'h0000_001F, 3, 4'h7);
        step(1'b1, 1'b1, 31, 32'h7FFF_FFFF, 4, 4'hF);
        step(1'b1, 1'b1, 32, 32'hFFFF_FFFF, 4, 4'hF);
        step(1'b1, 1'b0, 0,  32'h0000_0000, 0, 4'h0);
        step(1'b1, 1'b0, 0,  32'h0000_0000, 0, 4'h0);

        // Stall: accept 9, one more enabled cycle, then en low for 3 cycles.
        step(1'b1, 1'b1, 9,  32'h0000_01FF, 2, 4'h3);
        step(1'b1, 1'b0, 3,  32'h0000_0007, 1, 4'h1);
        step(1'b0, 1'b1, 17, 32'h0001_FFFF, 4, 4'hF);
        step(1'b0, 1'b1, 16, 32'h0000_FFFF, 4, 4'hF);
        step(1'b0, 1'b0, 0,  32'h0000_0000, 0, 4'h0);
        step(1'b1, 1'b0, 0,  32'h0000_0000, 0, 4'h0);
        step(1'b1, 1'b0, 0,  32'h0000_0000, 0, 4'h0);

        // Saturation above OutBits on both widths.
        for (int c = 33; c <= 63; c++) begin
            step(1'b1, 1'b1, c, 32'hFFFF_FFFF, 5 + (c % 3), 4'hF);
        end
        step(1'b1, 1'b1, 32, 32'hFFFF_FFFF, 4, 4'hF);
        step(1'b1, 1'b1, 16, 32'h0000_FFFF, 0, 4'h0);
        step(1'b1, 1'b1, 17, 32'h0001_FFFF, 1, 4'h1);
        step(1'b1, 1'b1, 3,  32'h0000_0007, 3, 4'h7);
        step(1'b1, 1'b0, 28, 32'h0FFF_FFFF, 2, 4'h3);

        // Reset mid-stream with data in flight.
        step(1'b1, 1'b1, 20, 32'h000F_FFFF, 4, 4'hF);
        step(1'b1, 1'b1, 2,  32'h0000_0003, 2, 4'h3);
        enter_reset();
        repeat (2) step(1'b1, 1'b1, 17, 32'h0001_FFFF, 3, 4'h7);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 8,  32'h0000_00FF, 1, 4'h1);
        step(1'b1, 1'b1, 12, 32'h0000_0FFF, 4, 4'hF);
        repeat (3) step(1'b1, 1'b0, 0, 32'h0000_0000, 0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
